// File: rtl/classifier_pkg.sv
// classifier_pkg: shared read-side FSM encoding and log2 helper for the frame sequencer
package classifier_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} seq_state_e;
  function automatic int log2c(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/classifier_result_fifo.sv
// classifier_result_fifo: first-word-fall-through result FIFO
// Ports: clk, reset_n (async active-low); push/wdata write side; pop/rdata FWFT head; full/empty flags.
// A push on a full FIFO still succeeds when a pop happens on the same edge.
module classifier_result_fifo import classifier_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = log2c(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // head reads as zero while empty so nothing stale is visible after reset
  assign rdata = empty ? '0 : mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(do_push);
      rp_q <= rp_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/classifier_frame_sequencer.sv
// classifier_frame_sequencer: multi-bank frame handoff between a frame writer and a classifier
// Ports: clk, reset_n (async active-low); writer side eof/wr_bank/wr_full; frame RAM read port
// ram_rd_*; classifier side cls_* (flag register, RAM window, result input, start);
// result side result/result_bank/result_valid/result_ready (FWFT); drop_count of rejected frames.
module classifier_frame_sequencer import classifier_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RESULT_W = 4,
  parameter int NUM_BANKS = 2,
  parameter int RES_DEPTH = 4,
  localparam int BANK_W = log2c(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     eof,
  output logic [BANK_W-1:0]        wr_bank,
  output logic                     wr_full,
  output logic                     ram_rd_en,
  output logic [BANK_W+ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0]        ram_rd_data,
  input  logic                     cls_flag_we,
  input  logic [7:0]               cls_flag_wdata,
  output logic [7:0]               cls_flag_rdata,
  input  logic                     cls_rd_en,
  input  logic [ADDR_W-1:0]        cls_address,
  output logic [DATA_W-1:0]        cls_rd_data,
  input  logic [RESULT_W-1:0]      cls_out_data,
  input  logic                     cls_out_valid,
  output logic                     cls_out_ready,
  output logic [RESULT_W-1:0]      result,
  output logic [BANK_W-1:0]        result_bank,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [15:0]              drop_count,
  output logic                     cls_start
);
  localparam int CNT_W = BANK_W + 1;
  seq_state_e state_q;
  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0] drop_q, drop_d;
  logic [1:0] sync_q;
  logic valid_q, accept, rel, fifo_full, fifo_empty;
  logic [BANK_W+RESULT_W-1:0] head;
  logic unused_flag_bits;
  assign unused_flag_bits = ^cls_flag_wdata[7:1];
  assign wr_full = count_q == CNT_W'(NUM_BANKS);
  assign accept = eof & ~wr_full;
  assign rel = (state_q == RUN) & cls_out_valid & cls_out_ready;
  assign wr_ptr_d = wr_ptr_q + BANK_W'(accept);
  assign rd_ptr_d = rd_ptr_q + BANK_W'(rel);
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(rel);
  assign drop_d = (eof & wr_full & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  assign wr_bank = wr_ptr_q;
  assign drop_count = drop_q;
  assign cls_start = sync_q[1];
  assign cls_flag_rdata = {7'b0, valid_q};
  assign ram_rd_en = cls_rd_en;
  assign ram_rd_addr = {rd_ptr_q, cls_address};
  assign cls_rd_data = ram_rd_data;
  assign cls_out_ready = ~fifo_full;
  assign result_valid = ~fifo_empty;
  assign result = head[RESULT_W-1:0];
  assign result_bank = head[RESULT_W +: BANK_W];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= '0;
      sync_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
      sync_q <= {sync_q[0], 1'b1};
    end
  end
  // valid_q is the classifier-visible input_valid flag; it is raised on arming and
  // only a write of 0 moves ARMED on to RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (count_q != '0 || accept) begin
            state_q <= ARMED;
            valid_q <= 1'b1;
          end else if (cls_flag_we) valid_q <= cls_flag_wdata[0];
        ARMED:
          if (cls_flag_we && !cls_flag_wdata[0]) begin
            state_q <= RUN;
            valid_q <= 1'b0;
          end
        RUN: begin
          if (cls_flag_we) valid_q <= cls_flag_wdata[0];
          if (rel) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  classifier_result_fifo #(.WIDTH(BANK_W + RESULT_W), .DEPTH(RES_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(rel),
    .wdata({rd_ptr_q, cls_out_data}),
    .pop(result_ready),
    .rdata(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_classifier_frame_sequencer.sv
// tb_classifier_frame_sequencer: directed self-checking bench for classifier_frame_sequencer
module tb_classifier_frame_sequencer;
  logic clk = 0;
  logic reset_n = 1;
  logic eof = 0;
  logic [0:0] wr_bank;
  logic wr_full, ram_rd_en;
  logic [10:0] ram_rd_addr;
  logic [15:0] ram_rd_data = 0;
  logic cls_flag_we = 0;
  logic [7:0] cls_flag_wdata = 0;
  logic [7:0] cls_flag_rdata;
  logic cls_rd_en = 0;
  logic [9:0] cls_address = 0;
  logic [15:0] cls_rd_data;
  logic [3:0] cls_out_data = 0;
  logic cls_out_valid = 0;
  logic cls_out_ready;
  logic [3:0] result;
  logic [0:0] result_bank;
  logic result_valid;
  logic result_ready = 0;
  logic [15:0] drop_count;
  logic cls_start;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  classifier_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .eof(eof), .wr_bank(wr_bank), .wr_full(wr_full),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .cls_flag_we(cls_flag_we), .cls_flag_wdata(cls_flag_wdata), .cls_flag_rdata(cls_flag_rdata),
    .cls_rd_en(cls_rd_en), .cls_address(cls_address), .cls_rd_data(cls_rd_data),
    .cls_out_data(cls_out_data), .cls_out_valid(cls_out_valid), .cls_out_ready(cls_out_ready),
    .result(result), .result_bank(result_bank), .result_valid(result_valid),
    .result_ready(result_ready), .drop_count(drop_count), .cls_start(cls_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_eof();
    eof = 1;
    tick();
    eof = 0;
  endtask

  task automatic clear_flag();
    cls_flag_we = 1;
    cls_flag_wdata = 8'h00;
    tick();
    cls_flag_we = 0;
  endtask

  task automatic give_result(input logic [3:0] d);
    cls_out_valid = 1;
    cls_out_data = d;
    tick();
    cls_out_valid = 0;
  endtask

  task automatic pop_one();
    result_ready = 1;
    tick();
    result_ready = 0;
  endtask

  initial begin
    #2 reset_n = 0;
    tick();
    tick();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_flag", cls_flag_rdata, 8'h00);
    chk("rst_start", cls_start, 0);
    reset_n = 1;
    tick();
    chk("start_edge1", cls_start, 0);
    tick();
    chk("start_edge2", cls_start, 1);
    tick();
    chk("idle_flag", cls_flag_rdata, 8'h00);

    // single frame into bank 0
    pulse_eof();
    chk("eof_flag", cls_flag_rdata, 8'h01);
    chk("eof_wr_bank", wr_bank, 1);
    clear_flag();
    chk("run_flag", cls_flag_rdata, 8'h00);
    cls_rd_en = 1;
    cls_address = 10'h005;
    ram_rd_data = 16'hBEEF;
    #1;
    chk("addr_bank0", ram_rd_addr, 11'h005);
    chk("rd_en", ram_rd_en, 1);
    chk("rd_data", cls_rd_data, 16'hBEEF);
    chk("ready_empty", cls_out_ready, 1);
    give_result(4'd7);
    chk("res1_data", result, 7);
    chk("res1_bank", result_bank, 0);
    chk("res1_valid", result_valid, 1);
    tick();
    chk("idle_no_rearm", cls_flag_rdata, 8'h00);
    pop_one();
    chk("pop1_valid", result_valid, 0);
    chk("pop1_result", result, 0);

    // second frame: bank 1 addressing, flag writes in ARMED and RUN
    pulse_eof();
    chk("f2_flag", cls_flag_rdata, 8'h01);
    cls_flag_we = 1;
    cls_flag_wdata = 8'h01;
    tick();
    cls_flag_we = 0;
    chk("armed_write1_ignored", cls_flag_rdata, 8'h01);
    clear_flag();
    chk("addr_bank1", ram_rd_addr, 11'h405);
    cls_flag_we = 1;
    cls_flag_wdata = 8'hFF;
    tick();
    chk("run_write1", cls_flag_rdata, 8'h01);
    cls_flag_wdata = 8'h00;
    tick();
    cls_flag_we = 0;
    chk("run_write0", cls_flag_rdata, 8'h00);
    give_result(4'd3);
    chk("res2_data", result, 3);
    chk("res2_bank", result_bank, 1);
    pop_one();
    cls_rd_en = 0;

    // simultaneous accepted eof and release with count=1
    pulse_eof();
    chk("sim_wr_bank_pre", wr_bank, 1);
    clear_flag();
    eof = 1;
    give_result(4'd9);
    eof = 0;
    chk("sim_wr_bank", wr_bank, 0);
    chk("sim_not_full", wr_full, 0);
    chk("sim_idle_flag", cls_flag_rdata, 8'h00);
    chk("sim_addr", ram_rd_addr, 11'h405);
    chk("sim_res_bank", result_bank, 0);
    chk("sim_res_data", result, 9);
    tick();
    chk("sim_rearm", cls_flag_rdata, 8'h01);
    pulse_eof();
    chk("sim_count_full", wr_full, 1);
    chk("full_wr_bank", wr_bank, 1);
    pulse_eof();
    chk("drop_in_full", drop_count, 1);
    chk("drop_wr_bank", wr_bank, 1);
    clear_flag();

    // asynchronous reset mid-RUN with both banks full and a pending result
    #2 reset_n = 0;
    #1;
    chk("arst_full", wr_full, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_flag", cls_flag_rdata, 8'h00);
    chk("arst_drop", drop_count, 0);
    chk("arst_wr_bank", wr_bank, 0);
    chk("arst_start", cls_start, 0);
    chk("arst_addr", ram_rd_addr, 11'h005);
    tick();
    reset_n = 1;
    tick();

    // overflow from a clean start
    pulse_eof();
    chk("ov1_full", wr_full, 0);
    chk("ov1_bank", wr_bank, 1);
    pulse_eof();
    chk("ov2_full", wr_full, 1);
    chk("ov2_bank", wr_bank, 0);
    pulse_eof();
    chk("ov3_drop", drop_count, 1);
    chk("ov3_bank", wr_bank, 0);
    chk("ov3_full", wr_full, 1);

    // backpressure: five frames, consumer stalled
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      pulse_eof();
      clear_flag();
      chk("bp_ready", cls_out_ready, 1);
      give_result(4'(i + 1));
    end
    chk("bp_full_ready", cls_out_ready, 0);
    chk("bp_head", result, 1);
    chk("bp_head_bank", result_bank, 0);
    pulse_eof();
    clear_flag();
    cls_out_valid = 1;
    cls_out_data = 4'd5;
    tick();
    tick();
    pulse_eof();
    chk("bp_held_in_run", wr_full, 1);
    chk("bp_still_blocked", cls_out_ready, 0);
    pop_one();
    chk("bp_ready_after_pop", cls_out_ready, 1);
    chk("bp_head2", result, 2);
    chk("bp_head2_bank", result_bank, 1);
    tick();
    cls_out_valid = 0;
    chk("bp_fifth_released", wr_full, 0);
    chk("bp_ready_full_again", cls_out_ready, 0);
    for (int i = 0; i < 3; i++) begin
      pop_one();
      chk("bp_drain_data", result, 32'(i + 3));
      chk("bp_drain_bank", result_bank, 32'((i + 2) % 2));
    end
    pop_one();
    chk("bp_drained", result_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
